// File: rtl/mdu_core_if.sv
// Control and data bundle between the decode/forwarding logic and the E-stage multiply/divide unit.
// The pipeline drives the master side, and the MDU sits on the slave side.
interface mdu_core_if #(
  parameter int unsigned DATA_W = 32
);
  logic              Start;
  logic [3:0]        MDUOP;
  logic [3:0]        Time;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [1:0]        ReadHILO;
  logic              Busy;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic [DATA_W-1:0] MDUOut;

  modport master (
    output Start, MDUOP, Time, A, B, ReadHILO,
    input  Busy, HI, LO, MDUOut
  );

  modport slave (
    input  Start, MDUOP, Time, A, B, ReadHILO,
    output Busy, HI, LO, MDUOut
  );
endinterface

// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit that owns the HI/LO registers.
// The result is computed when an op launches and held until its busy window ends.
module mdu_core #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MIN_LAT = 1
) (
  input logic       clk,
  input logic       reset,
  mdu_core_if.slave mdu_io
);

  localparam logic [3:0] OpMult  = 4'b0001;
  localparam logic [3:0] OpMultu = 4'b0010;
  localparam logic [3:0] OpDiv   = 4'b0011;
  localparam logic [3:0] OpDivu  = 4'b0100;
  localparam logic [3:0] OpMthi  = 4'b0101;
  localparam logic [3:0] OpMtlo  = 4'b0110;
  localparam logic [3:0] OpBds   = 4'b1000;
  localparam logic [3:0] MinLat  = 4'(MIN_LAT);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] res_hi_q, res_lo_q;
  logic              res_we_q;

  logic [DATA_W-1:0]   a, b;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   a_mag, b_mag, uq, ur, sq, sr, x, pop;
  logic [DATA_W-1:0]   res_hi_d, res_lo_d;
  logic                res_we_d, timed_op, launch;
  logic [3:0]          lat;

  assign a = mdu_io.A;
  assign b = mdu_io.B;

  always_comb begin
    prod_s = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    prod_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    // Signed division is done on magnitudes so that MIN_INT / -1 wraps without a special case.
    a_mag  = a[DATA_W-1] ? -a : a;
    b_mag  = b[DATA_W-1] ? -b : b;
    uq     = a_mag / b_mag;
    ur     = a_mag % b_mag;
    sq     = (a[DATA_W-1] ^ b[DATA_W-1]) ? -uq : uq;
    sr     = a[DATA_W-1] ? -ur : ur;
    x      = a ^ b;
    pop    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop = pop + DATA_W'(x[i]);
    end
  end

  always_comb begin
    res_hi_d = '0;
    res_lo_d = '0;
    res_we_d = 1'b1;
    timed_op = 1'b1;
    case (mdu_io.MDUOP)
      OpMult:  {res_hi_d, res_lo_d} = prod_s;
      OpMultu: {res_hi_d, res_lo_d} = prod_u;
      OpDiv: begin
        if (b == '0) begin
          res_we_d = 1'b0;
        end else begin
          res_hi_d = sr;
          res_lo_d = sq;
        end
      end
      OpDivu: begin
        if (b == '0) begin
          res_we_d = 1'b0;
        end else begin
          res_hi_d = a % b;
          res_lo_d = a / b;
        end
      end
      OpBds: begin
        res_hi_d = pop;
        res_lo_d = x;
      end
      default: begin
        res_we_d = 1'b0;
        timed_op = 1'b0;
      end
    endcase
  end

  assign launch = mdu_io.Start && timed_op && (state_q == StIdle);
  assign lat    = (mdu_io.Time < MinLat) ? MinLat : mdu_io.Time;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      res_we_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (launch) begin
            state_q  <= StRun;
            cnt_q    <= lat;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
          end else if (mdu_io.MDUOP == OpMthi) begin
            hi_q <= a;
          end else if (mdu_io.MDUOP == OpMtlo) begin
            lo_q <= a;
          end
        end
        StRun: begin
          if (cnt_q <= 4'd1) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            res_we_q <= 1'b0;
            if (res_we_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mdu_io.Busy = (state_q == StRun);
  assign mdu_io.HI   = hi_q;
  assign mdu_io.LO   = lo_q;

  always_comb begin
    case (mdu_io.ReadHILO)
      2'b10:   mdu_io.MDUOut = hi_q;
      2'b01:   mdu_io.MDUOut = lo_q;
      default: mdu_io.MDUOut = '0;
    endcase
  end

endmodule
